decode_issue_arbiter: RTL

- Merges the outputs of numPorts format-specific decode-2 decoders (B-form, D-form, etc.) into one decoded-instruction stream for the issue stage.
- Each decoder port has its own FIFO. A round-robin arbiter drains the FIFOs into a registered output.
- Backpressure is a valid/stall handshake in both directions: per-port stall_o to the decoders, stall_i from issue.

---
 rtl/decode_issue_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/decode_issue_arbiter.sv
// Merges per-decoder instruction streams into one issue stream: each port has a
// small FIFO, and a round-robin arbiter drains them into a registered output.
module decode_issue_arbiter #(
    parameter int numPorts                = 4,
    parameter int payloadWidth            = 96,
    parameter int instructionCounterWidth = 64,
    parameter int fifoDepth               = 4,
    parameter int portIdWidth             = 2
) (
    input  logic                                              clock_i,
    input  logic                                              reset_i,
    input  logic [numPorts-1:0]                               enable_i,
    input  logic [numPorts*payloadWidth-1:0]                  payload_i,
    input  logic [numPorts*instructionCounterWidth-1:0]       instMajId_i,
    output logic [numPorts-1:0]                               stall_o,
    input  logic                                              stall_i,
    output logic                                              enable_o,
    output logic [payloadWidth-1:0]                           payload_o,
    output logic [instructionCounterWidth-1:0]                instMajId_o,
    output logic [portIdWidth-1:0]                            portId_o,
    output logic [numPorts*($clog2(fifoDepth)+1)-1:0]         occupancy_o
);

    localparam int ptrWidth = $clog2(fifoDepth);
    localparam int cntWidth = ptrWidth + 1;

    logic [cntWidth-1:0]                count_q  [numPorts];
    logic [ptrWidth-1:0]                rd_ptr_q [numPorts];
    logic [ptrWidth-1:0]                wr_ptr_q [numPorts];
    logic [payloadWidth-1:0]            pay_mem  [numPorts][fifoDepth];
    logic [instructionCounterWidth-1:0] id_mem   [numPorts][fifoDepth];

    logic [portIdWidth-1:0] rr_ptr_q;
    logic [portIdWidth-1:0] rr_next;
    logic [portIdWidth-1:0] grant;
    logic [portIdWidth-1:0] scan_idx;
    logic                   grant_valid;
    logic [numPorts-1:0]    full;
    logic [numPorts-1:0]    push;
    logic [numPorts-1:0]    pop;

    // Stall depends only on the registered count, so a full FIFO never passes
    // a same-cycle push through even when it is being popped.
    always_comb begin
        full        = '0;
        push        = '0;
        occupancy_o = '0;
        for (int p = 0; p < numPorts; p++) begin
            full[p] = (count_q[p] == cntWidth'(fifoDepth));
            push[p] = enable_i[p] && !full[p];
            occupancy_o[p*cntWidth +: cntWidth] = count_q[p];
        end
    end

    assign stall_o = full;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        scan_idx    = '0;
        pop         = '0;
        for (int i = 0; i < numPorts; i++) begin
            scan_idx = portIdWidth'((int'(rr_ptr_q) + i) % numPorts);
            if (!grant_valid && (count_q[scan_idx] != '0)) begin
                grant_valid = 1'b1;
                grant       = scan_idx;
            end
        end
        rr_next = portIdWidth'((int'(grant) + 1) % numPorts);
        if (!stall_i && grant_valid) begin
            pop[grant] = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int p = 0; p < numPorts; p++) begin
                count_q[p]  <= '0;
                rd_ptr_q[p] <= '0;
                wr_ptr_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < numPorts; p++) begin
                if (push[p]) begin
                    wr_ptr_q[p] <= wr_ptr_q[p] + ptrWidth'(1);
                end
                if (pop[p]) begin
                    rd_ptr_q[p] <= rd_ptr_q[p] + ptrWidth'(1);
                end
                if (push[p] && !pop[p]) begin
                    count_q[p] <= count_q[p] + cntWidth'(1);
                end else if (!push[p] && pop[p]) begin
                    count_q[p] <= count_q[p] - cntWidth'(1);
                end
            end
        end
    end

    // Storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clock_i) begin
        for (int p = 0; p < numPorts; p++) begin
            if (!reset_i && push[p]) begin
                pay_mem[p][wr_ptr_q[p]] <= payload_i[p*payloadWidth +: payloadWidth];
                id_mem[p][wr_ptr_q[p]]  <= instMajId_i[p*instructionCounterWidth +: instructionCounterWidth];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            enable_o    <= 1'b0;
            payload_o   <= '0;
            instMajId_o <= '0;
            portId_o    <= '0;
            rr_ptr_q    <= '0;
        end else if (!stall_i) begin
            if (grant_valid) begin
                enable_o    <= 1'b1;
                payload_o   <= pay_mem[grant][rd_ptr_q[grant]];
                instMajId_o <= id_mem[grant][rd_ptr_q[grant]];
                portId_o    <= grant;
                rr_ptr_q    <= rr_next;
            end else begin
                enable_o <= 1'b0;
            end
        end
    end

endmodule
